// File: rtl/parser_pkg.sv
// Shared widths, tag bit positions and FSM states for the
// packet head builder feeding the parser.
package parser_pkg;
  localparam int DATA_WIDTH    = 128;
  localparam int HEAD_WIDTH    = 512;
  localparam int META_WIDTH    = 32;
  localparam int TAG_START_BIT = 8;
  localparam int TAG_WIDTH     = TAG_START_BIT + 4;

  localparam int HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH;
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int HEAD_BYTES = HEAD_WIDTH / 8;
  localparam int BYTES_W    = $clog2(BEAT_BYTES) + 1;
  localparam int CNT_W      = (HEAD_BEATS > 1) ? $clog2(HEAD_BEATS) : 1;

  localparam int TAG_VALID  = TAG_WIDTH - 1;
  localparam int TAG_LAYER0 = TAG_WIDTH - 2;
  localparam int TAG_SHORT  = TAG_WIDTH - 3;
  localparam int TAG_BODY   = TAG_WIDTH - 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    BODY
  } state_t;

  typedef logic [TAG_START_BIT-1:0] pkt_id_t;
endpackage

// File: rtl/pkt_head_builder_if.sv
// Beat stream in, tagged head/meta and body stream out.
interface pkt_head_builder_if;
  import parser_pkg::*;

  logic [DATA_WIDTH-1:0]           i_data;
  logic                            i_valid;
  logic                            i_sop;
  logic                            i_eop;
  logic [BYTES_W-1:0]              i_bytes;
  logic [7:0]                      i_port;
  logic                            o_ready;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head;
  logic [META_WIDTH+TAG_WIDTH-1:0] o_meta;
  logic [DATA_WIDTH-1:0]           o_body_data;
  logic                            o_body_valid;
  logic                            o_body_eop;
  logic [BYTES_W-1:0]              o_body_bytes;
  logic                            i_body_ready;
  logic [15:0]                     o_err_cnt;

  modport master (
    output i_data, i_valid, i_sop, i_eop, i_bytes, i_port,
    output i_body_ready,
    input  o_ready, o_head, o_meta, o_err_cnt,
    input  o_body_data, o_body_valid, o_body_eop, o_body_bytes
  );

  modport slave (
    input  i_data, i_valid, i_sop, i_eop, i_bytes, i_port,
    input  i_body_ready,
    output o_ready, o_head, o_meta, o_err_cnt,
    output o_body_data, o_body_valid, o_body_eop, o_body_bytes
  );
endinterface

// File: rtl/pkt_head_builder_mask.sv
// Zeroes bytes at or past the valid byte count on the last beat.
module head_byte_mask
  import parser_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  eop,
  input  logic [BYTES_W-1:0]    bytes,
  output logic [DATA_WIDTH-1:0] masked
);
  always_comb begin
    masked = data;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      if (eop && (BYTES_W'(b) >= bytes))
        masked[DATA_WIDTH-1-8*b -: 8] = 8'h00;
    end
  end
endmodule

// File: rtl/pkt_head_builder.sv
// Captures packet heads into tagged head/meta bubbles and
// forwards the remaining beats through a one-deep body register.
module pkt_head_builder
  import parser_pkg::*;
(
  input logic i_clk,
  input logic i_rst,
  pkt_head_builder_if.slave bus
);
  state_t state, state_nx;
  logic [CNT_W-1:0] beat_cnt, slot;
  logic [HEAD_WIDTH-1:0] head_buf, head_nx;
  logic [DATA_WIDTH-1:0] beat_m;
  logic [7:0] port_q, port_nx;
  pkt_id_t pkt_id;
  logic [15:0] err_cnt, nbytes;
  logic [TAG_WIDTH-1:0] tag;
  logic [META_WIDTH+TAG_WIDTH-1:0] meta_nx, meta_q;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] body_data;
  logic body_valid, body_eop;
  logic [BYTES_W-1:0] body_bytes;
  logic acc, start, capture, full, emit, fwd, err_inc;

  head_byte_mask u_mask (
    .data   (bus.i_data),
    .eop    (bus.i_eop),
    .bytes  (bus.i_bytes),
    .masked (beat_m)
  );

  assign bus.o_ready = (state != BODY) | bus.i_body_ready | ~body_valid;
  assign acc = bus.i_valid & bus.o_ready;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    capture  = 1'b0;
    fwd      = 1'b0;
    err_inc  = 1'b0;
    if (acc) begin
      unique case (state)
        IDLE: begin
          start   = bus.i_sop;
          err_inc = ~bus.i_sop;
        end
        COLLECT: begin
          capture = 1'b1;
          start   = bus.i_sop;
          err_inc = bus.i_sop;
        end
        BODY: begin
          start   = bus.i_sop;
          err_inc = bus.i_sop;
          fwd     = ~bus.i_sop;
          if (~bus.i_sop && bus.i_eop) state_nx = IDLE;
        end
        default: ;
      endcase
    end
    capture = capture | start;
    slot    = start ? '0 : beat_cnt;
    full    = (slot == CNT_W'(HEAD_BEATS - 1));
    emit    = capture & (bus.i_eop | full);
    if (capture)
      state_nx = bus.i_eop ? IDLE : (full ? BODY : COLLECT);
    port_nx = start ? bus.i_port : port_q;
    nbytes  = 16'(slot) * 16'(BEAT_BYTES)
            + (bus.i_eop ? 16'(bus.i_bytes) : 16'(BEAT_BYTES));
    // A fresh sop clears the window so unfilled slots read as zero.
    head_nx = start ? '0 : head_buf;
    for (int k = 0; k < HEAD_BEATS; k++) begin
      if (slot == CNT_W'(k))
        head_nx[HEAD_WIDTH-1-DATA_WIDTH*k -: DATA_WIDTH] = beat_m;
    end
    tag = '0;
    tag[TAG_VALID]  = 1'b1;
    tag[TAG_LAYER0] = 1'b1;
    tag[TAG_SHORT]  = nbytes < 16'(HEAD_BYTES);
    tag[TAG_BODY]   = ~bus.i_eop;
    tag[TAG_START_BIT-1:0] = pkt_id;
    meta_nx = '0;
    meta_nx[META_WIDTH+TAG_VALID] = 1'b1;
    meta_nx[META_WIDTH +: TAG_START_BIT] = pkt_id;
    meta_nx[23:16] = port_nx;
    meta_nx[15:0]  = nbytes;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      head_buf   <= '0;
      port_q     <= '0;
      pkt_id     <= '0;
      err_cnt    <= '0;
      head_q     <= '0;
      meta_q     <= '0;
      body_data  <= '0;
      body_valid <= 1'b0;
      body_eop   <= 1'b0;
      body_bytes <= '0;
    end else begin
      state  <= state_nx;
      head_q <= '0;
      meta_q <= '0;
      if (capture) begin
        head_buf <= head_nx;
        beat_cnt <= slot + 1'b1;
        port_q   <= port_nx;
      end
      if (emit) begin
        head_q <= {tag, head_nx};
        meta_q <= meta_nx;
        pkt_id <= pkt_id + 1'b1;
      end
      if (err_inc && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 1'b1;
      if (fwd) begin
        body_data  <= bus.i_data;
        body_valid <= 1'b1;
        body_eop   <= bus.i_eop;
        body_bytes <= bus.i_eop ? bus.i_bytes : BYTES_W'(BEAT_BYTES);
      end else if (bus.i_body_ready) begin
        body_valid <= 1'b0;
      end
    end
  end

  // An aborting sop closes the body beat still on the output.
  assign bus.o_body_eop = body_eop
    | ((state == BODY) & bus.i_valid & bus.i_sop & body_valid);
  assign bus.o_head       = head_q;
  assign bus.o_meta       = meta_q;
  assign bus.o_body_data  = body_data;
  assign bus.o_body_valid = body_valid;
  assign bus.o_body_bytes = body_bytes;
  assign bus.o_err_cnt    = err_cnt;
endmodule

// File: tb/tb_pkt_head_builder.sv
// Scoreboard bench: heads, metas and body beats are predicted
// when packets are driven and compared as the DUT emits them.
module tb_pkt_head_builder;
  import parser_pkg::*;

  localparam int CW = HEAD_WIDTH + TAG_WIDTH;
  typedef logic [CW-1:0] cv_t;
  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic                  eop;
    logic [BYTES_W-1:0]    bytes;
  } body_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_id = 8'd0;

  cv_t exp_head[$];
  logic [META_WIDTH+TAG_WIDTH-1:0] exp_meta[$];
  body_t exp_body[$];
  int head_cyc[$];

  pkt_head_builder_if bus ();

  pkt_head_builder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input cv_t got, input cv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] mk_beat(
    input int len, input logic [7:0] seed, input int k
  );
    logic [DATA_WIDTH-1:0] d;
    int nb;
    int idx;
    nb = (len + BEAT_BYTES - 1) / BEAT_BYTES;
    d = '0;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      idx = k * BEAT_BYTES + b;
      if (idx < len) d[DATA_WIDTH-1-8*b -: 8] = seed + 8'(idx);
      else if (nb <= HEAD_BEATS) d[DATA_WIDTH-1-8*b -: 8] = 8'hEE;
    end
    return d;
  endfunction

  task automatic send_beat(
    input logic [DATA_WIDTH-1:0] d, input logic sop, input logic eop,
    input logic [BYTES_W-1:0] nb, input logic [7:0] port
  );
    int n;
    n = 0;
    bus.i_data  = d;
    bus.i_sop   = sop;
    bus.i_eop   = eop;
    bus.i_bytes = nb;
    bus.i_port  = port;
    bus.i_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", cv_t'(bus.o_ready), cv_t'(1));
    @(posedge clk);
    #2;
    bus.i_valid = 1'b0;
  endtask

  task automatic send_pkt(
    input int len, input logic [7:0] port, input logic [7:0] seed,
    input int nsend
  );
    int nb;
    int cap;
    int last;
    logic [HEAD_WIDTH-1:0] h;
    logic [TAG_WIDTH-1:0] t;
    body_t bb;
    nb   = (len + BEAT_BYTES - 1) / BEAT_BYTES;
    cap  = (len < HEAD_BYTES) ? len : HEAD_BYTES;
    last = len - BEAT_BYTES * (nb - 1);
    if (nsend >= nb) begin
      h = '0;
      for (int i = 0; i < cap; i++) h[HEAD_WIDTH-1-8*i -: 8] = seed + 8'(i);
      t = {1'b1, 1'b1, cap < HEAD_BYTES, len > HEAD_BYTES, exp_id};
      exp_head.push_back({t, h});
      exp_meta.push_back({4'b1000, exp_id, 8'h00, port, 16'(cap)});
      exp_id = exp_id + 8'd1;
      for (int k = HEAD_BEATS; k < nb; k++) begin
        bb.data  = mk_beat(len, seed, k);
        bb.eop   = (k == nb - 1);
        bb.bytes = bb.eop ? BYTES_W'(last) : BYTES_W'(BEAT_BYTES);
        exp_body.push_back(bb);
      end
    end
    for (int k = 0; k < nsend && k < nb; k++)
      send_beat(mk_beat(len, seed, k), k == 0, k == nb - 1,
                (k == nb - 1) ? BYTES_W'(last) : BYTES_W'(BEAT_BYTES), port);
  endtask

  always @(negedge clk) begin
    cv_t eh;
    body_t eb;
    if (bus.o_head[CW-1]) begin
      head_cyc.push_back(cyc);
      if (exp_head.size() == 0) begin
        check("head_unexpected", bus.o_head, '0);
      end else begin
        eh = exp_head.pop_front();
        check("head", bus.o_head, eh);
        check("meta", cv_t'(bus.o_meta), cv_t'(exp_meta.pop_front()));
      end
    end else begin
      check("bubble", bus.o_head | cv_t'(bus.o_meta), '0);
    end
    if (bus.o_body_valid && bus.i_body_ready) begin
      if (exp_body.size() == 0) begin
        check("body_unexpected", cv_t'(bus.o_body_valid), '0);
      end else begin
        eb = exp_body.pop_front();
        check("body_data", cv_t'(bus.o_body_data), cv_t'(eb.data));
        check("body_eop", cv_t'(bus.o_body_eop), cv_t'(eb.eop));
        check("body_bytes", cv_t'(bus.o_body_bytes), cv_t'(eb.bytes));
      end
    end
  end

  initial begin
    bus.i_data = '0;
    bus.i_valid = 1'b0;
    bus.i_sop = 1'b0;
    bus.i_eop = 1'b0;
    bus.i_bytes = '0;
    bus.i_port = '0;
    bus.i_body_ready = 1'b1;

    @(negedge clk);
    check("rst_head", bus.o_head, '0);
    check("rst_meta", cv_t'(bus.o_meta), '0);
    check("rst_err", cv_t'(bus.o_err_cnt), '0);
    check("rst_bvalid", cv_t'(bus.o_body_valid), '0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", cv_t'(bus.o_ready), cv_t'(1));
    @(posedge clk);
    #2;

    send_pkt(64, 8'h11, 8'h00, 99);
    send_pkt(60, 8'h22, 8'h40, 99);

    bus.i_body_ready = 1'b0;
    fork
      send_pkt(100, 8'h33, 8'h80, 99);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_body_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen", cv_t'(bus.o_body_valid), cv_t'(1));
        for (int i = 0; i < 5; i++) begin
          check("stall_ready", cv_t'(bus.o_ready), '0);
          check("stall_data", cv_t'(bus.o_body_data),
                cv_t'(mk_beat(100, 8'h80, HEAD_BEATS)));
          @(negedge clk);
        end
        @(posedge clk);
        #2 bus.i_body_ready = 1'b1;
      end
    join

    send_pkt(80, 8'h44, 8'hA0, 1);
    send_pkt(32, 8'h55, 8'hC0, 99);
    check("abort_err", cv_t'(bus.o_err_cnt), cv_t'(1));

    send_beat(mk_beat(16, 8'h10, 0), 1'b0, 1'b1, BYTES_W'(16), 8'h66);
    check("drop_err", cv_t'(bus.o_err_cnt), cv_t'(2));

    send_pkt(80, 8'h77, 8'h30, 2);
    bus.i_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("async_err", cv_t'(bus.o_err_cnt), '0);
    check("async_head", bus.o_head, '0);
    check("async_bvalid", cv_t'(bus.o_body_valid), '0);
    bus.i_valid = 1'b0;
    exp_id = 8'd0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    head_cyc.delete();
    for (int i = 0; i < 8; i++)
      send_pkt(16, 8'(i), 8'(16 * i), 99);
    repeat (3) @(negedge clk);
    check("b2b_count", cv_t'(head_cyc.size()), cv_t'(8));
    for (int i = 1; i < head_cyc.size(); i++)
      check("b2b_gap", cv_t'(head_cyc[i] - head_cyc[i-1]), cv_t'(1));

    repeat (10) @(negedge clk);
    check("head_drain", cv_t'(exp_head.size()), '0);
    check("body_drain", cv_t'(exp_body.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/pkt_head_builder.md
# pkt_head_builder

Front-end stage feeding `Parser_Top`: it accepts a beat-oriented packet stream and captures the first `HEAD_WIDTH` bits of each packet into a tagged head vector. It also builds a matching tagged meta vector. Both are driven as one-cycle bubbles into `Parser_Top.i_head`/`i_meta`. Bytes beyond the head window are forwarded on a separate body stream with valid/ready handshake.

## Interface
- `DATA_WIDTH`, 128, input/body beat width in bits; `HEAD_WIDTH % DATA_WIDTH == 0`
- `HEAD_BEATS`, `HEAD_WIDTH/DATA_WIDTH`, derived; beats captured per head
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; one clock, asynchronous, active-high
- `i_data`  in  DATA_WIDTH  packet beat, first byte in MSBs
- `i_valid`  in  1  beat valid
- `i_sop`  in  1  first beat of packet
- `i_eop`  in  1  last beat of packet
- `i_bytes`  in  $clog2(DATA_WIDTH/8)+1  valid bytes on eop beat (1..DATA_WIDTH/8), ignored otherwise
- `i_port`  in  8  ingress port, sampled on sop beat
- `o_ready`  out  1  beat accepted when `i_valid & o_ready`
- `o_head`  out  HEAD_WIDTH+TAG_WIDTH  tagged head to parser
- `o_meta`  out  META_WIDTH+TAG_WIDTH  tagged meta to parser
- `o_body_data`/`o_body_valid`/`o_body_eop`/`o_body_bytes`  out  DATA_WIDTH/1/1/as `i_bytes`  post-head beats
- `i_body_ready`  in  1  body sink ready
- `o_err_cnt`  out  16  saturating protocol-error counter

## Operation
- Tag layout (package): bit TAG_WIDTH-1 valid, TAG_WIDTH-2 layer0, TAG_WIDTH-3 short, TAG_WIDTH-4 body-follows, [TAG_START_BIT-1:0] pkt_id. Bubble = all-zero vector.
- FSM states IDLE, COLLECT, BODY.
- IDLE: accepted beat with sop → store beat at slot 0, latch `i_port`, beat_cnt=1. If eop is also set, emit and stay IDLE. Otherwise go to COLLECT (or BODY if HEAD_BEATS==1).
- IDLE: accepted beat without sop → drop it, increment err.
- COLLECT: beat stored at slot beat_cnt, i.e. bits [HEAD_WIDTH-1-DATA_WIDTH*k -: DATA_WIDTH].
  - eop → emit, go to IDLE.
  - beat_cnt reaches HEAD_BEATS → emit with body-follows=1, go to BODY.
- BODY: beats pass to body port. eop → IDLE.
- sop in COLLECT or BODY → abort: increment err, discard partial head (nothing emitted). In BODY also force `o_body_eop` on the previous forwarded beat's slot. Then treat the beat as a new IDLE sop.
- Emit contents:
  - head data = captured slots. Bytes past the last valid byte are zero; unfilled slots are zero.
  - tag = {1,1,short,body,pkt_id}; short=1 iff captured bytes < HEAD_WIDTH/8.
  - meta = {1,0,0,0,pkt_id, zero.., port[23:16], captured_bytes[15:0]} in the low META_WIDTH bits.
  - pkt_id increments after each emit and wraps modulo 2^TAG_START_BIT.
- `o_ready` = 1 in IDLE/COLLECT; = `i_body_ready | ~o_body_valid` in BODY (one-deep skid register).
- err counter saturates at 16'hFFFF.

## Timing
- Reset values: `o_head`, `o_meta`, `o_body_*`, `o_err_cnt`, pkt_id all 0; state IDLE; `o_ready` 1 after reset release.
- `o_head`/`o_meta` are registered: valid for exactly one cycle, the cycle after the completing beat is accepted; zero otherwise.
- Head output never stalls (parser has no backpressure). Back-to-back single-beat packets yield heads on consecutive cycles.
- Body latency is 1 cycle. `o_body_data` holds while `o_body_valid & ~i_body_ready`.
- Reset mid-packet: partial head is discarded, no emit, body output clears immediately (async).

## Structure
- Tag bit indices, `HEAD_BEATS`, and FSM enum go in `parser_pkg` beside `HEAD_WIDTH`/`META_WIDTH`/`TAG_WIDTH`/`TAG_START_BIT`.
- One sub-module, `head_byte_mask`: combinational zeroing of bytes ≥ `i_bytes` on the eop beat.

## Test plan
Bench configuration: HEAD_WIDTH=512, DATA_WIDTH=128.
- TCP 64 B, 4 beats, last eop bytes=16 → one head = the 512-bit frame; tag {1,1,0,0,id 0}; meta bytes=64.
- ARP 60 B, eop on beat 3 with bytes=12 → last 4 bytes zero; short=1; meta bytes=60; pkt_id=1.
- 100 B packet → head = first 64 B with body=1; body port emits 3 beats, last eop bytes=4. Hold `i_body_ready` low 5 cycles → `o_ready` low and data stable.
- sop on beat 2 of a packet → err=1, no head for it, new packet emitted normally.
- Eight 1-beat packets back-to-back → heads on 8 consecutive cycles, ids 0..7.
- Async `i_rst` asserted during COLLECT → outputs zero at once; next packet gets pkt_id 0.
